// File: rtl/lorenz_euler_engine.sv
// Fixed-point Euler integrator for the Lorenz attractor. A single shared signed
// multiplier is sequenced over seven phases per step, followed by a state commit.
module lorenz_euler_engine #(
    parameter int WIDTH = 27,
    parameter int FRAC  = 20,
    parameter int STEPW = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    halt,
    input  logic                    step_en,
    input  logic [STEPW-1:0]        num_steps,
    input  logic signed [WIDTH-1:0] x0,
    input  logic signed [WIDTH-1:0] y0,
    input  logic signed [WIDTH-1:0] z0,
    input  logic signed [WIDTH-1:0] sigma,
    input  logic signed [WIDTH-1:0] rho,
    input  logic signed [WIDTH-1:0] beta,
    input  logic signed [WIDTH-1:0] dt,
    output logic signed [WIDTH-1:0] x_out,
    output logic signed [WIDTH-1:0] y_out,
    output logic signed [WIDTH-1:0] z_out,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    ovf
);

    typedef enum logic [1:0] {IDLE, CALC, UPDATE, FINISH} state_t;

    localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    state_t                  state_q;
    logic [2:0]              phase_q;
    logic [STEPW-1:0]        steps_left_q;
    logic signed [WIDTH-1:0] x_q, y_q, z_q;
    logic signed [WIDTH-1:0] sigma_q, rho_q, beta_q, dt_q;
    logic signed [WIDTH-1:0] p_q, q_q, dx_q, dy_q, dz_q;
    logic                    out_valid_q, done_q, ovf_q;

    logic signed [WIDTH-1:0]   sub_a, sub_b, sub_res;
    logic signed [WIDTH-1:0]   mul_a, mul_b, mul_res;
    logic signed [WIDTH-1:0]   x_d, y_d, z_d;
    logic signed [2*WIDTH-1:0] prod, prod_sh;
    logic                      sub_sat, sub_used, mul_sat, calc_sat;
    logic                      x_sat, y_sat, z_sat;

    // Returns {saturated, result} for a clamped add or subtract.
    function automatic logic [WIDTH:0] add_sat(input logic signed [WIDTH-1:0] a,
                                               input logic signed [WIDTH-1:0] b,
                                               input logic sub);
        logic [WIDTH:0] s;
        if (sub) s = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        else     s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        if (s[WIDTH] != s[WIDTH-1]) return {1'b1, (s[WIDTH] ? MINV : MAXV)};
        return {1'b0, s[WIDTH-1:0]};
    endfunction

    always_comb begin
        sub_a    = y_q;
        sub_b    = x_q;
        sub_used = 1'b0;
        case (phase_q)
            3'd0: sub_used = 1'b1;
            3'd2: begin sub_a = rho_q; sub_b = z_q; sub_used = 1'b1; end
            3'd3: begin sub_a = p_q;   sub_b = y_q; sub_used = 1'b1; end
            3'd6: begin sub_a = p_q;   sub_b = q_q; sub_used = 1'b1; end
            default: ;
        endcase
    end

    assign {sub_sat, sub_res} = add_sat(sub_a, sub_b, 1'b1);

    always_comb begin
        mul_a = sigma_q;
        mul_b = sub_res;
        case (phase_q)
            3'd1: begin mul_a = dt_q;   mul_b = p_q; end
            3'd2: mul_a = x_q;
            3'd3: mul_a = dt_q;
            3'd4: begin mul_a = x_q;    mul_b = y_q; end
            3'd5: begin mul_a = beta_q; mul_b = z_q; end
            3'd6: mul_a = dt_q;
            default: ;
        endcase
    end

    // Arithmetic shift floors the product; the top WIDTH+1 bits must agree to fit.
    assign prod     = (2*WIDTH)'(mul_a) * (2*WIDTH)'(mul_b);
    assign prod_sh  = prod >>> FRAC;
    assign mul_sat  = !((&prod_sh[2*WIDTH-1:WIDTH-1]) || !(|prod_sh[2*WIDTH-1:WIDTH-1]));
    assign mul_res  = mul_sat ? (prod_sh[2*WIDTH-1] ? MINV : MAXV) : prod_sh[WIDTH-1:0];
    assign calc_sat = mul_sat | (sub_used & sub_sat);

    assign {x_sat, x_d} = add_sat(x_q, dx_q, 1'b0);
    assign {y_sat, y_d} = add_sat(y_q, dy_q, 1'b0);
    assign {z_sat, z_d} = add_sat(z_q, dz_q, 1'b0);

    // Pulses clear every cycle; halt wins over everything and ignores step_en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            phase_q      <= 3'd0;
            steps_left_q <= '0;
            x_q          <= '0;
            y_q          <= '0;
            z_q          <= '0;
            sigma_q      <= '0;
            rho_q        <= '0;
            beta_q       <= '0;
            dt_q         <= '0;
            p_q          <= '0;
            q_q          <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            dz_q         <= '0;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            if (state_q != IDLE && halt) begin
                state_q <= IDLE;
                phase_q <= 3'd0;
            end else if (step_en) begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            x_q          <= x0;
                            y_q          <= y0;
                            z_q          <= z0;
                            sigma_q      <= sigma;
                            rho_q        <= rho;
                            beta_q       <= beta;
                            dt_q         <= dt;
                            ovf_q        <= 1'b0;
                            steps_left_q <= num_steps;
                            phase_q      <= 3'd0;
                            if (num_steps == '0) begin
                                state_q <= FINISH;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= CALC;
                            end
                        end
                    end
                    CALC: begin
                        case (phase_q)
                            3'd0, 3'd2, 3'd4: p_q <= mul_res;
                            3'd1:             dx_q <= mul_res;
                            3'd3:             dy_q <= mul_res;
                            3'd5:             q_q <= mul_res;
                            default:          dz_q <= mul_res;
                        endcase
                        if (calc_sat) ovf_q <= 1'b1;
                        if (phase_q == 3'd6) begin
                            state_q <= UPDATE;
                            phase_q <= 3'd0;
                        end else begin
                            phase_q <= phase_q + 3'd1;
                        end
                    end
                    UPDATE: begin
                        x_q          <= x_d;
                        y_q          <= y_d;
                        z_q          <= z_d;
                        if (x_sat || y_sat || z_sat) ovf_q <= 1'b1;
                        out_valid_q  <= 1'b1;
                        steps_left_q <= steps_left_q - STEPW'(1);
                        phase_q      <= 3'd0;
                        if (steps_left_q == STEPW'(1)) begin
                            state_q <= FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign x_out     = x_q;
    assign y_out     = y_q;
    assign z_out     = z_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign ovf       = ovf_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/lorenz_euler_engine.md
Name: lorenz_euler_engine

Overview:
Parametrised fixed-point Euler solver for the Lorenz system. It replaces the per-equation combinational multiplier trees and free-running integrators with one shared signed multiplier, sequenced by an FSM. It runs a requested number of Euler steps from a loaded initial state and streams each new (x,y,z) to the audio/VGA consumers. A step-enable input lets it run on the divided analog-update strobe.

Parameters:
WIDTH, 27, total signed two's-complement width of every state, coefficient and output
FRAC, 20, fractional bits (default format 7.20)
STEPW, 16, width of step counter / num_steps

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  begin a run; sampled only in IDLE
halt  in  1  abort the run; sampled in any non-IDLE state
step_en  in  1  FSM advances only on cycles with step_en=1; tie high for full rate
num_steps  in  STEPW  Euler steps to run; latched on start
x0,y0,z0  in  WIDTH  initial state, latched on start
sigma,rho,beta,dt  in  WIDTH  coefficients, latched on start
x_out,y_out,z_out  out  WIDTH  current committed state
out_valid  out  1  one-cycle pulse: new state committed
busy  out  1  high in every non-IDLE state
done  out  1  one-cycle pulse: run completed normally
ovf  out  1  sticky saturation flag; cleared on accepted start

Behaviour:
- Reset (async): FSM=IDLE; x/y/z_out=0; out_valid=done=busy=ovf=0; step counter=0.
- States: IDLE, CALC (phase 0..6), UPDATE, FINISH.
- IDLE + start=1: latch inputs; x/y/z_out <= x0/y0/z0; ovf<=0; steps_left<=num_steps.
  - num_steps=0: go to FINISH.
  - otherwise: go to CALC phase 0.
  - start is ignored in every other state.
- CALC: one multiply per enabled cycle into product register P. Phases:
  - 0: P=sigma*(y-x)
  - 1: dx=dt*P
  - 2: P=x*(rho-z)
  - 3: dy=dt*(P-y)
  - 4: P=x*y
  - 5: Q=beta*z
  - 6: dz=dt*(P-Q)
  - x,y,z are the committed state at step start.
- UPDATE (enabled cycle): x+=dx, y+=dy, z+=dz; out_valid=1 in the following cycle with the new values already on x/y/z_out; steps_left-=1.
  - steps_left reaches 0: go to FINISH.
  - otherwise: go to CALC phase 0.
- Step cost: 8 enabled cycles.
- FINISH: done=1 for one cycle, then IDLE. For the last step, done coincides with out_valid.
- step_en=0: FSM and all datapath registers hold; pulses are not generated or stretched.
- Arithmetic:
  - Multiply: full 2*WIDTH-bit product, arithmetic shift right FRAC (floor truncation).
  - Every add, subtract and product result saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Any saturation sets ovf, which holds until the next accepted start.
- halt=1 in a non-IDLE state: go to IDLE at the next edge, independent of step_en.
  - The partial step is discarded and the last committed state is retained.
  - No out_valid or done pulse.
  - halt has priority over UPDATE in the same cycle.
- Coefficients are latched, so input changes mid-run have no effect.
- reset mid-run: immediate return to the reset values above.

Test Plan:
- Reset then idle: all outputs 0, busy=0; start=0 for 100 cycles -> no pulses.
- Single step, step_en=1, defaults, sigma=10, rho=28, beta=8/3, dt=2^-8, state (-1, 0.1, 25), num_steps=1:
  - busy for 8 cycles, then out_valid+done together.
  - x=-0.95703125, y~0.087890625, z~24.739193 (within 2 LSB).
  - ovf=0.
- Multi-step with step_en=1 every 4th cycle, num_steps=3:
  - out_valid spaced 32 clocks apart.
  - Exactly 3 out_valid pulses; done with the 3rd.
  - Results match a bit-accurate floor-truncating model.
- num_steps=0: done one cycle after start, out_valid=0, outputs=x0/y0/z0. A start pulse during busy is ignored (no restart, same done timing).
- Saturation: x=60, y=-60, sigma=10, dt=1, num_steps=1.
  - sigma*(y-x) clamps to -64 and ovf=1.
  - ovf stays 1 after done and clears on the next start.
- Abort/reset: halt in CALC phase 3 of step 2 -> IDLE, state equals step-1 output, no done. Async reset asserted mid-step -> outputs 0 immediately, without waiting for a clock edge.
